// File: rtl/check_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : check_sequencer
// Purpose : Walks the channel self-test, samples per-channel pass bits and
//           sends the 64-bit status word to the Ethernet block over req/ack.
// Rev     : 1.0
// ============================================================================
module check_sequencer #(
  parameter int N_CH       = 8,
  parameter int SETTLE     = 100,
  parameter int TX_TIMEOUT = 4096
) (
  input  logic        clk_100Mz,
  input  logic        reset,
  input  logic        start,
  input  logic        auto_run,
  input  logic [7:0]  ready_channel,
  input  logic [7:0]  status_sum_addr_0_6_inz,
  input  logic [7:0]  status_sum_addr_7_8_zspa_ispr_kod,
  input  logic [7:0]  active_channel_res_ttl,
  input  logic        tx_ack,
  output logic [2:0]  j,
  output logic        drive_en,
  output logic [63:0] status_channel,
  output logic        tx_req,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int C_CMAX = (SETTLE > TX_TIMEOUT) ? SETTLE : TX_TIMEOUT;
  localparam int C_CW   = $clog2(C_CMAX + 1);
  localparam logic [7:0] C_CH_MASK = 8'((16'd1 << N_CH) - 16'd1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_GAP     = 3'd4,
    ST_PUBLISH = 3'd5,
    ST_SEND    = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  state_t            r_state;
  logic [C_CW-1:0]   r_cnt;
  logic [2:0]        r_j;
  logic              r_drive_en;
  logic [63:0]       r_status;
  logic              r_tx_req;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout_err;
  logic [15:0]       r_run_count;
  logic [7:0]        r_sh_a, r_sh_s, r_sh_z, r_sh_r;

  logic              w_run_start;
  logic [7:0]        w_fail;
  logic [15:0]       w_rc_next;

  // Unused channels keep all-ones shadows; the mask also forces their F bits low.
  assign w_fail      = ~(r_sh_a & r_sh_s & r_sh_z & r_sh_r) & C_CH_MASK;
  assign w_rc_next   = r_run_count + 16'd1;
  assign w_run_start = ((r_state == ST_IDLE) && start) ||
                       ((r_state == ST_DONE) && auto_run);

  always_ff @(posedge clk_100Mz) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_j           <= 3'd0;
      r_drive_en    <= 1'b0;
      r_status      <= '1;
      r_tx_req      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_run_count   <= 16'd0;
      r_sh_a        <= '1;
      r_sh_s        <= '1;
      r_sh_z        <= '1;
      r_sh_r        <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: ;
        ST_SELECT: begin
          r_cnt   <= C_CW'(SETTLE - 1);
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == '0) r_state <= ST_SAMPLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_SAMPLE: begin
          r_sh_a[r_j] <= ready_channel[r_j];
          r_sh_s[r_j] <= status_sum_addr_0_6_inz[r_j];
          r_sh_z[r_j] <= status_sum_addr_7_8_zspa_ispr_kod[r_j];
          r_sh_r[r_j] <= active_channel_res_ttl[r_j];
          r_drive_en  <= 1'b0;
          r_state     <= ST_GAP;
        end
        ST_GAP: begin
          if (r_j == 3'(N_CH - 1)) begin
            r_state <= ST_PUBLISH;
          end else begin
            r_j        <= r_j + 3'd1;
            r_drive_en <= 1'b1;
            r_state    <= ST_SELECT;
          end
        end
        ST_PUBLISH: begin
          r_run_count <= w_rc_next;
          r_status    <= {r_sh_r, r_sh_s, r_sh_z, r_sh_a, w_rc_next, w_fail, 8'hA5};
          r_tx_req    <= 1'b1;
          r_cnt       <= '0;
          r_state     <= ST_SEND;
        end
        ST_SEND: begin
          // An ack on the expiry cycle still counts as a successful send.
          if (tx_ack) begin
            r_tx_req <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (r_cnt == C_CW'(TX_TIMEOUT - 1)) begin
            r_tx_req      <= 1'b0;
            r_done        <= 1'b1;
            r_timeout_err <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_run_start) begin
        r_state       <= ST_SELECT;
        r_j           <= 3'd0;
        r_drive_en    <= 1'b1;
        r_busy        <= 1'b1;
        r_timeout_err <= 1'b0;
        r_sh_a        <= '1;
        r_sh_s        <= '1;
        r_sh_z        <= '1;
        r_sh_r        <= '1;
      end
    end
  end

  assign j              = r_j;
  assign drive_en       = r_drive_en;
  assign status_channel = r_status;
  assign tx_req         = r_tx_req;
  assign busy           = r_busy;
  assign done           = r_done;
  assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_check_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_check_sequencer
// Purpose : Self-checking bench for check_sequencer (table runs + random runs).
// Rev     : 1.0
// ============================================================================
module tb_check_sequencer;

  localparam int N_CH       = 8;
  localparam int SETTLE     = 100;
  localparam int TX_TIMEOUT = 4096;
  localparam int P          = SETTLE + 3;

  logic        clk_100Mz = 1'b0;
  logic        reset, start, auto_run, tx_ack;
  logic [7:0]  ready_channel, ssum06, ssum78, act_ttl;
  logic [2:0]  j;
  logic        drive_en, tx_req, busy, done, timeout_err;
  logic [63:0] status_channel;

  check_sequencer #(.N_CH(N_CH), .SETTLE(SETTLE), .TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk_100Mz                         (clk_100Mz),
    .reset                             (reset),
    .start                             (start),
    .auto_run                          (auto_run),
    .ready_channel                     (ready_channel),
    .status_sum_addr_0_6_inz           (ssum06),
    .status_sum_addr_7_8_zspa_ispr_kod (ssum78),
    .active_channel_res_ttl            (act_ttl),
    .tx_ack                            (tx_ack),
    .j                                 (j),
    .drive_en                          (drive_en),
    .status_channel                    (status_channel),
    .tx_req                            (tx_req),
    .busy                              (busy),
    .done                              (done),
    .timeout_err                       (timeout_err)
  );

  always #5 clk_100Mz = ~clk_100Mz;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: channel captures for the current run, run counter.
  logic [7:0] mA, mS, mZ, mR;
  logic [7:0] cA, cS, cZ, cR;
  int         m_rc;
  int         m_fault;
  bit         m_rand;
  bit         m_stop_auto;

  typedef struct {
    int          ack;
    int          fault;
    logic [7:0]  a, s, z, r;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_100Mz);
    #1;
  endtask

  function automatic logic [63:0] model_word();
    logic [7:0] f;
    f = 8'h00;
    for (int k = 0; k < N_CH; k++) f[k] = ~(mA[k] & mS[k] & mZ[k] & mR[k]);
    return {mR, mS, mZ, mA, 16'(m_rc), f, 8'hA5};
  endfunction

  // Drive inputs for run cycle c and record what lands in each channel's sample slot.
  task automatic drive_inputs(input int c);
    if (m_rand) begin
      ready_channel = 8'($urandom);
      ssum06        = 8'($urandom | $urandom);
      ssum78        = 8'($urandom | $urandom);
      act_ttl       = 8'($urandom | $urandom);
    end else begin
      ready_channel = cA;
      ssum06        = cS;
      ssum78        = cZ;
      act_ttl       = cR;
      if (m_fault >= 0 && c == (m_fault + 1) * P - 1) ready_channel[m_fault] = 1'b0;
    end
    for (int k = 0; k < N_CH; k++) begin
      if (c == (k + 1) * P - 1) begin
        mA[k] = ready_channel[k];
        mS[k] = ssum06[k];
        mZ[k] = ssum78[k];
        mR[k] = act_ttl[k];
      end
    end
  endtask

  // Called while observing cycle 0 (IDLE sampling start, or DONE with auto_run).
  // Returns while observing the DONE cycle of this run.
  task automatic run_one(input int ack_delay, input bit rand_start, output logic [63:0] word);
    logic [63:0] exp_word;
    int          c;
    mA = '1; mS = '1; mZ = '1; mR = '1;
    m_rc = (m_rc + 1) % 65536;
    for (c = 1; c <= N_CH * P + 1; c++) begin
      tick();
      chk("busy_run", busy, 1'b1);
      chk("tx_req_low", tx_req, 1'b0);
      chk("done_low", done, 1'b0);
      if (c <= N_CH * P) begin
        chk("j_seq", j, 64'((c - 1) / P));
        chk("drive_en_seq", drive_en, 64'(((c - 1) % P) != (P - 1)));
      end else begin
        chk("j_publish", j, 64'(N_CH - 1));
        chk("drive_en_publish", drive_en, 1'b0);
      end
      if (c == 1) begin
        chk("timeout_err_cleared", timeout_err, 1'b0);
        if (m_stop_auto) auto_run = 1'b0;
      end
      start  = (rand_start && c < N_CH * P) ? 1'($urandom_range(0, 1)) : 1'b0;
      tx_ack = m_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_inputs(c);
    end
    exp_word = model_word();
    word = '0;
    for (int s = 0; s < TX_TIMEOUT; s++) begin
      tick();
      chk("tx_req_high", tx_req, 1'b1);
      chk("done_send", done, 1'b0);
      chk("drive_en_send", drive_en, 1'b0);
      if (s == 0) begin
        word = status_channel;
        chk("status_model", status_channel, exp_word);
      end else begin
        chk("status_stable", status_channel, word);
      end
      tx_ack = (s == ack_delay);
      if (s == ack_delay) break;
    end
    tick();
    tx_ack = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("tx_req_dropped", tx_req, 1'b0);
    chk("busy_done", busy, 1'b1);
    chk("timeout_err_done", timeout_err, 64'(ack_delay < 0));
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;

    tbl[0] = '{ack: 3,    fault: -1, a: 8'hFF, s: 8'hFF, z: 8'hFF, r: 8'hFF, exp: 64'hFFFF_FFFF_0001_00A5};
    tbl[1] = '{ack: 1,    fault: 3,  a: 8'hFF, s: 8'hFF, z: 8'hFF, r: 8'hFF, exp: 64'hFFFF_FFF7_0002_08A5};
    tbl[2] = '{ack: 0,    fault: -1, a: 8'h00, s: 8'h00, z: 8'h00, r: 8'h00, exp: 64'h0000_0000_0003_FFA5};
    tbl[3] = '{ack: 2,    fault: -1, a: 8'h0F, s: 8'hF0, z: 8'hFF, r: 8'hFF, exp: 64'hFFF0_FF0F_0004_FFA5};
    tbl[4] = '{ack: 4095, fault: -1, a: 8'hFF, s: 8'hFF, z: 8'hFF, r: 8'h55, exp: 64'h55FF_FFFF_0005_AAA5};
    tbl[5] = '{ack: 5,    fault: -1, a: 8'hFF, s: 8'hFF, z: 8'h7E, r: 8'hFF, exp: 64'hFFFF_7EFF_0006_81A5};

    reset = 1'b1; start = 1'b0; auto_run = 1'b0; tx_ack = 1'b0;
    ready_channel = 8'hFF; ssum06 = 8'hFF; ssum78 = 8'hFF; act_ttl = 8'hFF;
    m_rc = 0; m_fault = -1; m_rand = 1'b0; m_stop_auto = 1'b0;
    cA = 8'hFF; cS = 8'hFF; cZ = 8'hFF; cR = 8'hFF;
    repeat (3) tick();
    reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      tick();
      chk("reset_status", status_channel, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("reset_tx_req", tx_req, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_j", j, 3'd0);
      chk("reset_drive_en", drive_en, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_timeout_err", timeout_err, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      cA = tbl[i].a; cS = tbl[i].s; cZ = tbl[i].z; cR = tbl[i].r;
      m_fault = tbl[i].fault;
      start = 1'b1;
      run_one(tbl[i].ack, 1'b0, w);
      chk("table_status", w, tbl[i].exp);
      tick();
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
    end

    // Send never acknowledged: sticky timeout, cleared by the next start.
    cA = 8'hFF; cS = 8'hFF; cZ = 8'hFF; cR = 8'hFF; m_fault = -1;
    start = 1'b1;
    run_one(-1, 1'b0, w);
    tick();
    chk("timeout_sticky", timeout_err, 1'b1);
    chk("timeout_idle_busy", busy, 1'b0);
    repeat (5) tick();
    chk("timeout_sticky_later", timeout_err, 1'b1);

    m_rand = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      run_one(int'($urandom_range(0, 5)), 1'b1, w);
      tick();
      chk("rand_idle_busy", busy, 1'b0);
    end

    // Reset during channel 5's settle window.
    m_rand = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 1 + 5 * P + 10; c++) begin
      tick();
      start = 1'b0;
    end
    chk("pre_reset_j", j, 3'd5);
    chk("pre_reset_drive_en", drive_en, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_rc = 0;
    chk("midreset_drive_en", drive_en, 1'b0);
    chk("midreset_j", j, 3'd0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_tx_req", tx_req, 1'b0);
    chk("midreset_status", status_channel, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midreset_done", done, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_reset_done", done, 1'b0);
      chk("post_reset_busy", busy, 1'b0);
    end

    // Back-to-back auto runs with immediate acks and stray start pulses.
    m_rand = 1'b1;
    auto_run = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_stop_auto = (i == 2);
      run_one(0, 1'b1, w);
      chk("auto_run_count", w[31:16], 64'(i + 1));
    end
    m_stop_auto = 1'b0;
    tick();
    chk("auto_final_idle", busy, 1'b0);
    chk("auto_final_done", done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/check_sequencer.md
# check_sequencer

Scheduler for the unit's channel self-test. It walks the channel index `j` through every analysed line. For each channel it enables the LVDS/TTL test drivers, waits a settle time, and samples the per-channel pass bits from the checkers. It then assembles the 64-bit `status_channel` word and hands it to the Ethernet transmitter over a req/ack handshake. It sits between the top-level start/delay logic and the checker blocks plus the Ethernet block.

## Interface
Parameters:
- `N_CH`, 8: number of channels checked per run; 1..8.
- `SETTLE`, 100: clk_100Mz cycles of settle per channel; must be ≥1.
- `TX_TIMEOUT`, 4096: cycles to wait for `tx_ack` before abandoning the send.

Ports:
- `clk_100Mz` in 1: single clock; all logic runs on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: level sampled in IDLE; high starts one run.
- `auto_run` in 1: when high, a new run begins immediately after each run, with no `start` needed.
- `ready_channel` in 8: per-channel pass bits, 1 = pass.
- `status_sum_addr_0_6_inz` in 8: per-channel pass bits.
- `status_sum_addr_7_8_zspa_ispr_kod` in 8: per-channel pass bits.
- `active_channel_res_ttl` in 8: per-channel pass bits.
- `tx_ack` in 1: Ethernet block has accepted `status_channel`.
- `j` out 3: channel currently under test.
- `drive_en` out 1: test drivers enabled for channel `j`.
- `status_channel` out 64: published status word.
- `tx_req` out 1: `status_channel` is valid and awaiting transmission.
- `busy` out 1: run in progress, i.e. state ≠ IDLE.
- `done` out 1: one-cycle pulse at the end of each run.
- `timeout_err` out 1: sticky; the last send timed out.

## Operation
- FSM states: IDLE, SELECT, SETTLE, SAMPLE, GAP, PUBLISH, SEND, DONE. All outputs are registered.
- **IDLE:** `start`=1 → SELECT, with `j`=0 and `timeout_err` cleared.
- **SELECT:** 1 cycle. `drive_en`=1 and the settle counter is loaded → SETTLE.
- **SETTLE:** exactly `SETTLE` cycles with `drive_en`=1 → SAMPLE.
- **SAMPLE:** 1 cycle with `drive_en`=1. Bit `j` of each of the four input vectors is captured into shadow registers A/S/Z/R[j]. Fail bit F[j] = ~(A&S&Z&R)[j].
- **GAP:** 1 cycle with `drive_en`=0.
  - If `j`=`N_CH`-1 → PUBLISH.
  - Otherwise `j`+1 → SELECT.
- **PUBLISH:** 1 cycle. `run_count` (16-bit, wraps 0xFFFF→0) increments, and `status_channel` is loaded:
  - [63:56] = R (`active_channel_res_ttl`)
  - [55:48] = S (`status_sum_addr_0_6_inz`)
  - [47:40] = Z (`status_sum_addr_7_8_zspa_ispr_kod`)
  - [39:32] = A (`ready_channel`)
  - [31:16] = new `run_count`
  - [15:8] = F
  - [7:0] = 0xA5
  - Shadow bits for channels ≥ `N_CH` read as 1; their F bits read as 0.
  - Then → SEND.
- **SEND:** `tx_req`=1. `status_channel` must stay stable while `tx_req`=1.
  - `tx_ack`=1 sampled → DONE.
  - `TX_TIMEOUT` cycles elapse without ack → set `timeout_err`, then DONE.
  - Ack in the same cycle as timeout expiry: ack wins, `timeout_err` stays 0.
- **DONE:** `done`=1 for 1 cycle.
  - `auto_run`=1 → SELECT with `j`=0.
  - Otherwise → IDLE.
- `start` outside IDLE is ignored. `tx_ack` outside SEND is ignored.
- `timeout_err` is cleared only by `reset` or the next run start.
- Shadow registers are cleared to all-ones at every run start.

## Timing
- Reset values:
  - `j`=0, `drive_en`=0, `tx_req`=0, `busy`=0, `done`=0, `timeout_err`=0.
  - `status_channel`=64'hFFFF_FFFF_FFFF_FFFF; `run_count`=0; shadows all-ones.
  - FSM in IDLE.
- `reset` asserted mid-run: all of the above take effect on the next edge, `tx_req` drops, and no `done` pulse is produced.
- Cycle 0 is the cycle where IDLE samples `start`=1. Channel k's SELECT is at cycle 1+k·(`SETTLE`+3).
- `drive_en` is high for `SETTLE`+2 consecutive cycles per channel, followed by 1 low cycle.
- Inputs are sampled at cycle (k+1)·(`SETTLE`+3)−1.
- PUBLISH is at cycle `N_CH`·(`SETTLE`+3)+1. `tx_req` and the new `status_channel` are visible from the following cycle. Defaults: PUBLISH at 825, visible from cycle 826.
- SEND → DONE handoff:
  - `tx_ack` sampled high in cycle t: `tx_req` is low from t+1, where `done`=1.
  - Auto-run: next SELECT at t+2.

## Test plan
- Reset, then idle 50 cycles → `status_channel`=all-ones, `tx_req`=0, `busy`=0, `j`=0.
- All four inputs 0xFF, `start` pulse at cycle 0, `tx_ack` answered 3 cycles after `tx_req` rises:
  - `tx_req` rises at cycle 826.
  - `status_channel` = 0xFFFF_FFFF_0001_00A5.
  - `done` pulses one cycle after the ack is sampled.
- `ready_channel`=0xFF except bit 3=0 during channel 3's sample window; others 0xFF → [39:32]=0xF7, [15:8]=0x08.
- `tx_ack` never asserted → `tx_req` held for exactly 4096 cycles, then `timeout_err`=1 and `done` pulses; the next `start` clears `timeout_err`.
- `auto_run`=1, immediate acks, three runs → `run_count` field reads 1, 2, 3; `start` pulses while `busy` have no effect.
- `reset` during channel 5's SETTLE → `drive_en`=0, `j`=0, `busy`=0 next cycle; `status_channel` unchanged from all-ones; no `done` pulse.
